// File: rtl/cabac_bin_sched.sv
// Sequencer between the CABAC syntax parser and the arithmetic bin decoder:
// buffers bitstream bytes, issues one gated decoder update per bin, returns bins.
module cabac_bin_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bs_valid,
    input  logic [7:0]       bs_data,
    output logic             bs_ready,
    input  logic             req_valid,
    input  logic             req_bypass,
    input  logic [7:0]       req_pState,
    input  logic             req_n_bin,
    output logic             req_ready,
    output logic             bin_valid,
    output logic [1:0]       bin_val,
    input  logic             bin_ready,
    output logic             dec_reset,
    output logic             dec_en,
    output logic             dec_bypass,
    output logic [7:0]       dec_pState,
    output logic             dec_n_bin,
    output logic [7:0]       dec_data,
    input  logic             dec_request_byte,
    input  logic [1:0]       dec_bin,
    output logic             busy,
    output logic [CNT_W-1:0] bin_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        READY  = 3'd2,
        ISSUE  = 3'd3,
        RESULT = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               byp_r;
    logic [7:0]         pstate_r;
    logic               nbin_r;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic [CNT_W-1:0]   bin_count_r;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               push_s;
    logic               pop_s;
    logic               stall_s;
    logic               accept_s;
    logic               bin_done_s;

    assign fifo_empty_s = (count_r == {(PTR_W+1){1'b0}});
    assign fifo_full_s  = (count_r == FULL_CNT);
    assign push_s       = bs_valid && !fifo_full_s;
    // A byte-starved decoder must not advance; the stall ends once a byte is buffered.
    assign stall_s      = dec_request_byte && fifo_empty_s;
    assign pop_s        = (state_r == ISSUE) && dec_request_byte && !fifo_empty_s;
    assign accept_s     = (state_r == READY) && !start && req_valid;
    assign bin_done_s   = (state_r == RESULT) && bin_ready;
    assign bin_count    = bin_count_r;

    // Next-state and decoder/handshake output decode
    always_comb begin
        next_state_s = state_r;
        req_ready    = 1'b0;
        bin_valid    = 1'b0;
        bin_val      = 2'b00;
        dec_reset    = 1'b0;
        dec_en       = 1'b0;
        dec_bypass   = 1'b0;
        dec_pState   = 8'h00;
        dec_n_bin    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = INIT;
                else       next_state_s = IDLE;
            end
            INIT: begin
                dec_reset    = 1'b1;
                next_state_s = READY;
            end
            READY: begin
                req_ready = !start;
                if (start)         next_state_s = INIT;
                else if (req_valid) next_state_s = ISSUE;
                else               next_state_s = READY;
            end
            ISSUE: begin
                dec_bypass = byp_r;
                dec_pState = pstate_r;
                dec_n_bin  = nbin_r;
                dec_en     = !stall_s;
                if (stall_s) next_state_s = ISSUE;
                else         next_state_s = RESULT;
            end
            RESULT: begin
                bin_valid = 1'b1;
                bin_val   = dec_bin;
                if (bin_ready) next_state_s = READY;
                else           next_state_s = RESULT;
            end
            default: next_state_s = IDLE;
        endcase
    end

    assign busy     = (state_r != IDLE) && (state_r != READY);
    assign bs_ready = !fifo_full_s;
    assign dec_data = fifo_empty_s ? 8'h00 : mem_r[rd_ptr_r];

    // State register and request latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            byp_r    <= 1'b0;
            pstate_r <= 8'h00;
            nbin_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                byp_r    <= req_bypass;
                pstate_r <= req_pState;
                nbin_r   <= req_n_bin;
            end
        end
    end

    // Byte FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Byte FIFO storage; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (push_s && !reset) mem_r[wr_ptr_r] <= bs_data;
    end

    // Delivered-bin counter, saturating
    always_ff @(posedge clk) begin
        if (reset || state_r == INIT) begin
            bin_count_r <= {CNT_W{1'b0}};
        end else if (bin_done_s && bin_count_r != {CNT_W{1'b1}}) begin
            bin_count_r <= bin_count_r + CNT_W'(1);
        end else begin
            bin_count_r <= bin_count_r;
        end
    end
endmodule

// File: tb/tb_cabac_bin_sched.sv
// Directed bench for cabac_bin_sched; bins and consumed bytes are checked
// by a negedge monitor against scoreboard queues filled by the stimulus.
module tb_cabac_bin_sched;
    logic        clk = 1'b0;
    logic        reset, start, bs_valid, bs_ready;
    logic [7:0]  bs_data;
    logic        req_valid, req_bypass, req_n_bin, req_ready;
    logic [7:0]  req_pState;
    logic        bin_valid, bin_ready;
    logic [1:0]  bin_val;
    logic        dec_reset, dec_en, dec_bypass, dec_n_bin, dec_request_byte, busy;
    logic [7:0]  dec_pState, dec_data;
    logic [1:0]  dec_bin;
    logic [15:0] bin_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic [1:0] exp_bins[$];
    logic [7:0] exp_bytes[$];

    cabac_bin_sched #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
        .req_valid(req_valid), .req_bypass(req_bypass), .req_pState(req_pState),
        .req_n_bin(req_n_bin), .req_ready(req_ready),
        .bin_valid(bin_valid), .bin_val(bin_val), .bin_ready(bin_ready),
        .dec_reset(dec_reset), .dec_en(dec_en), .dec_bypass(dec_bypass),
        .dec_pState(dec_pState), .dec_n_bin(dec_n_bin), .dec_data(dec_data),
        .dec_request_byte(dec_request_byte), .dec_bin(dec_bin),
        .busy(busy), .bin_count(bin_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: bins at the output handshake, bytes at each consuming update
    always @(negedge clk) begin
        if (!reset && bin_valid && bin_ready) begin
            chk("bin_pending", {31'd0, exp_bins.size() != 0}, 32'd1);
            if (exp_bins.size() != 0) chk("bin_val", {30'd0, bin_val}, {30'd0, exp_bins.pop_front()});
        end
        if (!reset && dec_en && dec_request_byte) begin
            chk("byte_pending", {31'd0, exp_bytes.size() != 0}, 32'd1);
            if (exp_bytes.size() != 0) chk("dec_data", {24'd0, dec_data}, {24'd0, exp_bytes.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic byp, input logic [7:0] ps, input logic nb,
                           input logic rb, input logic [1:0] b);
        req_valid = 1'b1; req_bypass = byp; req_pState = ps; req_n_bin = nb;
        dec_request_byte = rb; dec_bin = b;
    endtask

    task automatic run_bin(input logic byp, input logic [7:0] ps, input logic nb,
                           input logic rb, input logic [1:0] b);
        int n;
        set_req(byp, ps, nb, rb, b);
        exp_bins.push_back(b);
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk("req_accept_timeout", {31'd0, n < 20}, 32'd1);
        step();
        req_valid = 1'b0;
        n = 0;
        while (!(bin_valid && bin_ready) && n < 50) begin step(); n++; end
        chk("bin_timeout", {31'd0, n < 50}, 32'd1);
        step();
        exp_count++;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = 8'h00;
        req_valid = 1'b0; req_bypass = 1'b0; req_pState = 8'h00; req_n_bin = 1'b0;
        bin_ready = 1'b1; dec_request_byte = 1'b0; dec_bin = 2'b00;
        step(); step();
        reset = 1'b0;
        repeat (5) step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_bin_valid", {31'd0, bin_valid}, 32'd0);
        chk("rst_dec_en", {31'd0, dec_en}, 32'd0);
        chk("rst_bs_ready", {31'd0, bs_ready}, 32'd1);
        chk("rst_bin_count", {16'd0, bin_count}, 32'd0);
        chk("rst_dec_data", {24'd0, dec_data}, 32'd0);

        // Start: one-cycle decoder reset, then ready for requests
        start = 1'b1; step(); start = 1'b0;
        chk("init_dec_reset", {31'd0, dec_reset}, 32'd1);
        chk("init_req_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("ready_dec_reset", {31'd0, dec_reset}, 32'd0);
        chk("ready_req_ready", {31'd0, req_ready}, 32'd1);

        // Regular bin, no byte needed
        set_req(1'b0, 8'h3A, 1'b1, 1'b0, 2'b01);
        exp_bins.push_back(2'b01);
        step(); req_valid = 1'b0;
        chk("iss_dec_en", {31'd0, dec_en}, 32'd1);
        chk("iss_pState", {24'd0, dec_pState}, 32'h3A);
        chk("iss_n_bin", {31'd0, dec_n_bin}, 32'd1);
        chk("iss_bypass", {31'd0, dec_bypass}, 32'd0);
        step();
        chk("res_bin_valid", {31'd0, bin_valid}, 32'd1);
        chk("res_dec_en", {31'd0, dec_en}, 32'd0);
        step(); exp_count++;
        chk("cnt_after_first", {16'd0, bin_count}, exp_count);

        // Bypass bin starved of bytes, then fed one
        set_req(1'b1, 8'h00, 1'b0, 1'b1, 2'b10);
        exp_bins.push_back(2'b10);
        step(); req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("stall_dec_en", {31'd0, dec_en}, 32'd0);
            chk("stall_bypass", {31'd0, dec_bypass}, 32'd1);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            step();
        end
        bs_valid = 1'b1; bs_data = 8'hA5; exp_bytes.push_back(8'hA5);
        chk("push_cycle_dec_en", {31'd0, dec_en}, 32'd0);
        step(); bs_valid = 1'b0;
        chk("fed_dec_data", {24'd0, dec_data}, 32'hA5);
        chk("fed_dec_en", {31'd0, dec_en}, 32'd1);
        step();
        chk("fed_fifo_empty", {24'd0, dec_data}, 32'h00);
        chk("fed_bin_valid", {31'd0, bin_valid}, 32'd1);
        step(); exp_count++;
        dec_request_byte = 1'b0;
        chk("cnt_after_bypass", {16'd0, bin_count}, exp_count);

        // Fill the FIFO, hold off a fifth byte, then consume three
        for (int i = 0; i < 4; i++) begin
            bs_valid = 1'b1; bs_data = 8'h11 * 8'(i + 1);
            exp_bytes.push_back(bs_data);
            step();
        end
        bs_data = 8'h55; exp_bytes.push_back(8'h55);
        chk("full_bs_ready", {31'd0, bs_ready}, 32'd0);
        step();
        chk("held_bs_ready", {31'd0, bs_ready}, 32'd0);
        set_req(1'b0, 8'h10, 1'b0, 1'b1, 2'b00);
        exp_bins.push_back(2'b00);
        step(); req_valid = 1'b0;
        chk("pop1_dec_data", {24'd0, dec_data}, 32'h11);
        chk("pop_full_bs_ready", {31'd0, bs_ready}, 32'd0);
        step();
        chk("after_pop_bs_ready", {31'd0, bs_ready}, 32'd1);
        step(); exp_count++; bs_valid = 1'b0;
        chk("refull_bs_ready", {31'd0, bs_ready}, 32'd0);
        run_bin(1'b0, 8'h11, 1'b1, 1'b1, 2'b11);
        run_bin(1'b1, 8'h00, 1'b0, 1'b1, 2'b01);
        chk("cnt_after_three", {16'd0, bin_count}, exp_count);

        // Consumer back-pressure in RESULT
        bin_ready = 1'b0;
        set_req(1'b0, 8'h20, 1'b0, 1'b0, 2'b11);
        exp_bins.push_back(2'b11);
        step(); req_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("hold_bin_valid", {31'd0, bin_valid}, 32'd1);
            chk("hold_bin_val", {30'd0, bin_val}, 32'd3);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_bin_count", {16'd0, bin_count}, exp_count);
            step();
        end
        bin_ready = 1'b1;
        step(); exp_count++;
        chk("cnt_after_hold", {16'd0, bin_count}, exp_count);

        // Reset while issuing with two bytes (0x44, 0x55) buffered
        set_req(1'b0, 8'h30, 1'b0, 1'b1, 2'b01);
        step(); req_valid = 1'b0;
        chk("pre_rst_head", {24'd0, dec_data}, 32'h44);
        reset = 1'b1; step(); reset = 1'b0;
        exp_bytes.delete(); exp_count = 0; dec_request_byte = 1'b0;
        chk("rst_iss_busy", {31'd0, busy}, 32'd0);
        chk("rst_iss_bin_valid", {31'd0, bin_valid}, 32'd0);
        chk("rst_iss_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_iss_bs_ready", {31'd0, bs_ready}, 32'd1);
        chk("rst_iss_fifo_empty", {24'd0, dec_data}, 32'h00);
        chk("rst_iss_bin_count", {16'd0, bin_count}, 32'd0);
        step();
        chk("rst_iss_no_bin", {31'd0, bin_valid}, 32'd0);

        // Reset during a starvation stall drops the request
        pulse_start();
        set_req(1'b1, 8'h00, 1'b0, 1'b1, 2'b10);
        step(); req_valid = 1'b0;
        step();
        chk("stall2_dec_en", {31'd0, dec_en}, 32'd0);
        chk("stall2_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; step(); reset = 1'b0; dec_request_byte = 1'b0;
        chk("rst_stall_busy", {31'd0, busy}, 32'd0);
        step();
        chk("rst_stall_no_bin", {31'd0, bin_valid}, 32'd0);

        // Start in READY keeps buffered bytes and clears the counter
        pulse_start();
        bs_valid = 1'b1; bs_data = 8'h66; exp_bytes.push_back(8'h66); step();
        bs_data = 8'h77; exp_bytes.push_back(8'h77); step();
        bs_valid = 1'b0;
        run_bin(1'b0, 8'h40, 1'b0, 1'b0, 2'b10);
        chk("cnt_before_restart", {16'd0, bin_count}, exp_count);
        start = 1'b1; req_valid = 1'b1; step();
        start = 1'b0; req_valid = 1'b0;
        chk("restart_dec_reset", {31'd0, dec_reset}, 32'd1);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        step(); exp_count = 0;
        chk("restart_bin_count", {16'd0, bin_count}, 32'd0);
        chk("restart_req_ready", {31'd0, req_ready}, 32'd1);
        chk("restart_fifo_kept", {24'd0, dec_data}, 32'h66);
        run_bin(1'b0, 8'h41, 1'b1, 1'b1, 2'b01);
        run_bin(1'b1, 8'h00, 1'b0, 1'b1, 2'b00);
        chk("cnt_final", {16'd0, bin_count}, exp_count);
        chk("final_fifo_empty", {24'd0, dec_data}, 32'h00);
        repeat (3) step();
        chk("bins_outstanding", exp_bins.size(), 32'd0);
        chk("bytes_outstanding", exp_bytes.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
